// File: rtl/alu_pkg.sv
// Shared definitions for the ALU/program-flow slice: widths, flow opcodes,
// status register bit positions and the flow controller state encoding.
package alu_pkg;

  localparam int WORD_W = 20;

  localparam logic [2:0] OP_TRAP = 3'd0;
  localparam logic [2:0] OP_NOP  = 3'd1;
  localparam logic [2:0] OP_JMP  = 3'd2;
  localparam logic [2:0] OP_JZ   = 3'd3;
  localparam logic [2:0] OP_JS   = 3'd4;
  localparam logic [2:0] OP_JZS  = 3'd5;
  localparam logic [2:0] OP_LSR  = 3'd6;
  localparam logic [2:0] OP_XSR  = 3'd7;

  localparam int SR_Z = 0;
  localparam int SR_S = 1;
  localparam int SR_C = 2;
  localparam int SR_T = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_TRAP   = 2'd1,
    ST_RESUME = 2'd2
  } flow_state_e;

endpackage

// File: rtl/flow_cond.sv
// Jump condition evaluation against the registered status flags.
module flow_cond
  import alu_pkg::*;
(
  input  logic [2:0] op_code,
  input  logic [2:0] cond_flags,
  output logic       jump_taken
);

  // Carry is carried along with the flags but no jump tests it.
  logic unused_carry;
  assign unused_carry = cond_flags[SR_C];

  always_comb begin
    jump_taken = 1'b0;
    case (op_code)
      OP_JMP:  jump_taken = 1'b1;
      OP_JZ:   jump_taken = cond_flags[SR_Z];
      OP_JS:   jump_taken = cond_flags[SR_S];
      OP_JZS:  jump_taken = cond_flags[SR_Z] | cond_flags[SR_S];
      default: jump_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flow_ctrl.sv
// Program-flow unit: owns PC, status register and saved return PC, and
// sequences trap entry/exit with the trap handler.
//
// state     | meaning
// ST_RUN    | accepting flow operations and sequential steps
// ST_TRAP   | trap raised, waiting for trap_ack
// ST_RESUME | one cycle restoring pc from epc
module flow_ctrl
  import alu_pkg::*;
#(
  parameter logic [WORD_W-1:0] TRAP_VEC = 20'h00010,
  parameter logic [WORD_W-1:0] RESET_PC = 20'h00000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flag_valid,
  input  logic              flag_zero,
  input  logic              flag_sign,
  input  logic              flag_carry,
  input  logic              seq_step,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_code,
  input  logic [WORD_W-1:0] op_target,
  output logic [WORD_W-1:0] pc,
  output logic [3:0]        sr,
  output logic              taken,
  output logic              trap_req,
  input  logic              trap_ack,
  output logic [WORD_W-1:0] epc
);

  flow_state_e       state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] epc_q, epc_d;
  logic [3:0]        sr_q, sr_d;
  logic              taken_q, taken_d;
  logic              jump_taken;
  logic              accept;
  logic [WORD_W-1:0] pc_inc;

  flow_cond u_cond (
    .op_code    (op_code),
    .cond_flags (sr_q[2:0]),
    .jump_taken (jump_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      sr_q    <= 4'b0000;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      sr_q    <= sr_d;
      taken_q <= taken_d;
    end
  end

  assign accept = op_valid & op_ready;
  assign pc_inc = pc_q + WORD_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    sr_d    = sr_q;
    taken_d = 1'b0;
    if (flag_valid) sr_d[2:0] = {flag_carry, flag_sign, flag_zero};
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          // Any accepted flow op owns the PC, so a coincident seq_step is dropped.
          case (op_code)
            OP_TRAP: begin
              epc_d       = pc_inc;
              pc_d        = TRAP_VEC;
              sr_d[SR_T]  = 1'b1;
              state_d     = ST_TRAP;
            end
            OP_JMP, OP_JZ, OP_JS, OP_JZS: begin
              pc_d    = jump_taken ? op_target : pc_inc;
              taken_d = jump_taken;
            end
            OP_LSR: begin
              sr_d[2:0] = op_target[2:0];
              pc_d      = pc_inc;
            end
            OP_XSR: begin
              sr_d[2:0] = sr_q[2:0] ^ op_target[2:0];
              pc_d      = pc_inc;
            end
            default: pc_d = pc_inc;
          endcase
        end else if (seq_step) begin
          pc_d = pc_inc;
        end
      end
      ST_TRAP: begin
        if (trap_ack) begin
          sr_d[SR_T] = 1'b0;
          state_d    = ST_RESUME;
        end
      end
      ST_RESUME: begin
        pc_d    = epc_q;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // op_ready follows rst_n directly so it is low for the whole reset.
  always_comb begin
    op_ready = rst_n && (state_q == ST_RUN);
    trap_req = (state_q == ST_TRAP);
    pc       = pc_q;
    sr       = sr_q;
    epc      = epc_q;
    taken    = taken_q;
  end

endmodule

// File: tb/tb_flow_ctrl.sv
// Directed bench for flow_ctrl: expectations are queued as stimulus is
// driven and drained against the DUT one cycle later.
module tb_flow_ctrl;
  import alu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flag_valid, flag_zero, flag_sign, flag_carry;
  logic              seq_step, op_valid, op_ready;
  logic [2:0]        op_code;
  logic [WORD_W-1:0] op_target;
  logic [WORD_W-1:0] pc, epc;
  logic [3:0]        sr;
  logic              taken, trap_req, trap_ack;

  typedef struct {
    string       sig;
    logic [31:0] exp;
  } exp_t;

  exp_t  sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "init";

  flow_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flag_valid (flag_valid),
    .flag_zero  (flag_zero),
    .flag_sign  (flag_sign),
    .flag_carry (flag_carry),
    .seq_step   (seq_step),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_code    (op_code),
    .op_target  (op_target),
    .pc         (pc),
    .sr         (sr),
    .taken      (taken),
    .trap_req   (trap_req),
    .trap_ack   (trap_ack),
    .epc        (epc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input string sig);
    case (sig)
      "pc":       return 32'(pc);
      "epc":      return 32'(epc);
      "sr":       return 32'(sr);
      "taken":    return 32'(taken);
      "trap_req": return 32'(trap_req);
      "op_ready": return 32'(op_ready);
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(input string sig, input logic [31:0] v);
    exp_t e;
    e.sig = sig;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      n_tests++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s/%s observed=%h expected=%h", phase, e.sig, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] code, input logic [WORD_W-1:0] tgt);
    op_valid  = 1'b1;
    op_code   = code;
    op_target = tgt;
    step();
    op_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flag_valid = 1'b0; flag_zero = 1'b0; flag_sign = 1'b0;
    flag_carry = 1'b0; seq_step = 1'b0; op_valid = 1'b0; op_code = OP_NOP;
    op_target = '0; trap_ack = 1'b0;

    phase = "reset";
    #12;
    expect_val("pc", 0); expect_val("sr", 0); expect_val("epc", 0);
    expect_val("taken", 0); expect_val("trap_req", 0); expect_val("op_ready", 0);
    drain();
    #10 rst_n = 1'b1;
    #1;
    expect_val("op_ready", 1);
    drain();
    @(negedge clk);

    phase = "seq_step";
    seq_step = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      expect_val("pc", 32'(i)); expect_val("taken", 0);
      step();
      drain();
    end
    seq_step = 1'b0;
    expect_val("sr", 0); expect_val("op_ready", 1);
    drain();

    phase = "flag_z";
    flag_valid = 1'b1; flag_zero = 1'b1;
    expect_val("sr", 4'b0001);
    step();
    flag_valid = 1'b0; flag_zero = 1'b0;
    drain();

    phase = "jz_taken";
    expect_val("pc", 20'h00ABC); expect_val("taken", 1);
    do_op(OP_JZ, 20'h00ABC);
    drain();
    phase = "taken_pulse";
    expect_val("taken", 0); expect_val("pc", 20'h00ABC);
    step();
    drain();

    phase = "js_not_taken";
    expect_val("pc", 20'h00ABD); expect_val("taken", 0);
    do_op(OP_JS, 20'h00100);
    drain();

    phase = "jzs_taken";
    expect_val("pc", 20'h00300); expect_val("taken", 1);
    do_op(OP_JZS, 20'h00300);
    drain();

    phase = "lsr_vs_flags";
    flag_valid = 1'b1; flag_zero = 1'b1; flag_sign = 1'b1; flag_carry = 1'b1;
    expect_val("sr", 4'b0010); expect_val("pc", 20'h00301);
    do_op(OP_LSR, 20'hFFFFA);
    flag_valid = 1'b0; flag_zero = 1'b0; flag_sign = 1'b0; flag_carry = 1'b0;
    drain();

    phase = "xsr";
    expect_val("sr", 4'b0101); expect_val("pc", 20'h00302);
    do_op(OP_XSR, 20'h00007);
    drain();

    phase = "jmp_vs_step";
    seq_step = 1'b1;
    expect_val("pc", 20'h00050); expect_val("taken", 1);
    do_op(OP_JMP, 20'h00050);
    seq_step = 1'b0;
    drain();

    phase = "trap_entry";
    do_op(OP_JMP, 20'h00200);
    expect_val("pc", 20'h00010); expect_val("epc", 20'h00201);
    expect_val("sr", 4'b1101); expect_val("trap_req", 1); expect_val("op_ready", 0);
    do_op(OP_TRAP, 20'h0);
    drain();

    phase = "trap_hold";
    op_valid = 1'b1; op_code = OP_JMP; op_target = 20'h00777; seq_step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_val("pc", 20'h00010); expect_val("trap_req", 1);
      step();
      drain();
    end
    op_valid = 1'b0; seq_step = 1'b0;

    phase = "trap_ack";
    trap_ack = 1'b1;
    expect_val("trap_req", 0); expect_val("op_ready", 0); expect_val("sr", 4'b0101);
    step();
    trap_ack = 1'b0;
    drain();
    phase = "resume";
    expect_val("pc", 20'h00201); expect_val("op_ready", 1); expect_val("sr", 4'b0101);
    step();
    drain();

    phase = "pc_wrap";
    do_op(OP_JMP, 20'hFFFFF);
    expect_val("pc", 20'h00000);
    do_op(OP_NOP, 20'h0);
    drain();

    phase = "epc_wrap";
    do_op(OP_JMP, 20'hFFFFF);
    expect_val("epc", 20'h00000); expect_val("pc", 20'h00010); expect_val("trap_req", 1);
    do_op(OP_TRAP, 20'h0);
    drain();

    phase = "reset_mid_trap";
    #2 rst_n = 1'b0;
    #1;
    expect_val("trap_req", 0); expect_val("pc", 0); expect_val("sr", 0);
    expect_val("epc", 0); expect_val("op_ready", 0);
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    trap_ack = 1'b1;
    expect_val("op_ready", 1); expect_val("pc", 0); expect_val("trap_req", 0);
    expect_val("sr", 0);
    step();
    trap_ack = 1'b0;
    drain();

    phase = "run_after_reset";
    expect_val("pc", 20'h00123); expect_val("taken", 1);
    do_op(OP_JMP, 20'h00123);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
